// File: rtl/stepper_axis_driver.sv
// Per-axis stepper driver: turns a latched move command (count, period,
// direction) into a timed step/dir pulse train plus a 4-phase full-step
// coil pattern. Reports busy, remaining steps and a one-cycle done pulse.
module stepper_axis_driver #(
    parameter int PULSE_W    = 4,
    parameter int MIN_PERIOD = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] steps_in,
    input  logic [CNT_W-1:0] period_in,
    input  logic             hold,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       phase,
    output logic [3:0]       coils
);

    localparam int                PW_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [PW_W-1:0]   PW_LOAD = PW_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0]  MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic             step_r;
    logic             dir_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] remaining_r;
    logic [1:0]       phase_r;
    logic [3:0]       coils_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PW_W-1:0]  pw_r;
    logic [CNT_W-1:0] period_eff_s;
    logic [1:0]       phase_next_s;
    logic [1:0]       phase_start_s;

    // Advance the electrical phase one full step in the given direction (mod 4).
    function automatic logic [1:0] phase_step(input logic [1:0] p, input logic fwd);
        logic [1:0] r;
        if (fwd) begin
            r = p + 2'd1;
        end else begin
            r = p - 2'd1;
        end
        return r;
    endfunction

    // One-hot coil drive for a phase, or all coils off when not energised.
    function automatic logic [3:0] coil_drive(input logic [1:0] p, input logic en);
        logic [3:0] r;
        if (en) begin
            case (p)
                2'd0:    r = 4'b0001;
                2'd1:    r = 4'b0010;
                2'd2:    r = 4'b0100;
                2'd3:    r = 4'b1000;
                default: r = 4'b0000;
            endcase
        end else begin
            r = 4'b0000;
        end
        return r;
    endfunction

    // Commanded periods shorter than the motor can follow are stretched.
    assign period_eff_s  = (period_in < MIN_P) ? MIN_P : period_in;
    assign phase_next_s  = phase_step(phase_r, dir_r);
    assign phase_start_s = phase_step(phase_r, dir_in);

    // Move sequencer: accepts commands, times steps, drives all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            step_r      <= 1'b0;
            dir_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            remaining_r <= '0;
            phase_r     <= 2'd0;
            coils_r     <= 4'b0000;
            period_r    <= '0;
            cnt_r       <= '0;
            pw_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    step_r <= 1'b0;
                    pw_r   <= '0;
                    if (start && !abort) begin
                        dir_r    <= dir_in;
                        period_r <= period_eff_s;
                        if (steps_in == '0) begin
                            // Empty move: no step, just the completion pulse.
                            state_r     <= FIN;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            remaining_r <= '0;
                            cnt_r       <= '0;
                            coils_r     <= coil_drive(phase_r, hold);
                        end else begin
                            // First step goes out on the accepting edge.
                            state_r     <= RUN;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                            step_r      <= 1'b1;
                            pw_r        <= PW_LOAD;
                            cnt_r       <= period_eff_s - CNT_ONE;
                            remaining_r <= steps_in - CNT_ONE;
                            phase_r     <= phase_start_s;
                            coils_r     <= coil_drive(phase_start_s, 1'b1);
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        coils_r <= coil_drive(phase_r, hold);
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    if (abort) begin
                        // Abort freezes remaining and phase; no completion pulse.
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        step_r  <= 1'b0;
                        pw_r    <= '0;
                        cnt_r   <= '0;
                        coils_r <= coil_drive(phase_r, hold);
                    end else if (cnt_r == '0) begin
                        if (remaining_r != '0) begin
                            step_r      <= 1'b1;
                            pw_r        <= PW_LOAD;
                            cnt_r       <= period_r - CNT_ONE;
                            remaining_r <= remaining_r - CNT_ONE;
                            phase_r     <= phase_next_s;
                            coils_r     <= coil_drive(phase_next_s, 1'b1);
                        end else begin
                            // Last step's full period has elapsed.
                            state_r <= FIN;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            step_r  <= 1'b0;
                            coils_r <= coil_drive(phase_r, hold);
                        end
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        step_r  <= (pw_r != '0);
                        coils_r <= coil_drive(phase_r, 1'b1);
                        if (pw_r != '0) begin
                            pw_r <= pw_r - PW_W'(1);
                        end else begin
                            pw_r <= pw_r;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    step_r  <= 1'b0;
                    coils_r <= coil_drive(phase_r, hold);
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    step_r  <= 1'b0;
                    coils_r <= 4'b0000;
                end
            endcase
        end
    end

    assign step      = step_r;
    assign dir       = dir_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign remaining = remaining_r;
    assign phase     = phase_r;
    assign coils     = coils_r;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Self-checking bench for stepper_axis_driver: per-scenario tasks push the
// expected step/done events to a scoreboard queue and pop them as the
// DUT produces them; per-cycle levels are compared against a schedule model.
module tb_stepper_axis_driver;

    localparam int PULSE_W    = 4;
    localparam int MIN_PERIOD = 8;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             dir_in;
    logic [CNT_W-1:0] steps_in;
    logic [CNT_W-1:0] period_in;
    logic             hold;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       phase;
    logic [3:0]       coils;

    typedef struct {
        logic             is_done;
        int               rel;
        logic [1:0]       ph;
        logic [CNT_W-1:0] rem;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [1:0] m_phase = 2'd0;
    logic       m_dir   = 1'b0;

    stepper_axis_driver #(
        .PULSE_W(PULSE_W), .MIN_PERIOD(MIN_PERIOD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir_in(dir_in),
        .steps_in(steps_in), .period_in(period_in), .hold(hold),
        .step(step), .dir(dir), .busy(busy), .done(done),
        .remaining(remaining), .phase(phase), .coils(coils)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] onehot(input logic [1:0] p);
        logic [3:0] r;
        r = 4'b0001 << p;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
        steps_in = '0; period_in = '0; hold = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({step, dir, busy, done, remaining, phase, coils} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got step=%b dir=%b busy=%b done=%b rem=%0d ph=%0d coils=%b want all zero",
                     step, dir, busy, done, remaining, phase, coils);
        end
        rst = 1'b0;
        m_phase = 2'd0; m_dir = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coils !== 4'b0001 || phase !== 2'd0 || busy !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got coils=%b ph=%0d busy=%b step=%b want coils=0001 ph=0 busy=0 step=0",
                     coils, phase, busy, step);
        end
    endtask

    // Runs one move and scores it; abort_at/restart_at < 0 means unused.
    task automatic do_move(input logic d, input int n, input int p,
                           input int abort_at, input int restart_at);
        int         peff, s, busy_end, rel_end, issued;
        logic       exp_busy, exp_step, prev_step;
        logic [1:0] ph;
        ev_t        e, got;
        peff   = (p < MIN_PERIOD) ? MIN_PERIOD : p;
        issued = 0;
        ph     = m_phase;
        for (int k = 1; k <= n; k++) begin
            if (abort_at < 0 || 1 + (k - 1) * peff <= abort_at) begin
                issued++;
                ph        = d ? ph + 2'd1 : ph - 2'd1;
                e.is_done = 1'b0; e.rel = 1 + (k - 1) * peff;
                e.ph      = ph;   e.rem = CNT_W'(n - k);
                exp_q.push_back(e);
            end
        end
        if (abort_at < 0) begin
            e.is_done = 1'b1; e.rel = n * peff + 1; e.ph = ph; e.rem = '0;
            exp_q.push_back(e);
        end
        busy_end = (abort_at < 0) ? n * peff : abort_at;
        rel_end  = busy_end + 3;
        @(negedge clk);
        dir_in = d; steps_in = CNT_W'(n); period_in = CNT_W'(p); start = 1'b1;
        s = cyc; prev_step = step; m_dir = d;
        for (int rel = 1; rel <= rel_end; rel++) begin
            @(negedge clk);
            if (cyc - s != rel) begin
                checks++; errors++;
                $display("FAIL cycle_align got %0d want %0d", cyc - s, rel);
            end
            if (rel <= busy_end && ((rel - 1) % peff) == 0) begin
                m_phase = d ? m_phase + 2'd1 : m_phase - 2'd1;
            end
            exp_busy = (rel <= busy_end);
            exp_step = exp_busy && (((rel - 1) % peff) < PULSE_W);
            checks++;
            if (busy !== exp_busy || step !== exp_step || phase !== m_phase ||
                coils !== ((exp_busy || hold) ? onehot(m_phase) : 4'b0000)) begin
                errors++;
                $display("FAIL levels rel=%0d got busy=%b step=%b ph=%0d coils=%b want busy=%b step=%b ph=%0d coils=%b",
                         rel, busy, step, phase, coils, exp_busy, exp_step, m_phase,
                         (exp_busy || hold) ? onehot(m_phase) : 4'b0000);
            end
            if (step === 1'b1 && prev_step === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step rel=%0d got step rise want none", rel);
                end else begin
                    got = exp_q.pop_front();
                    if (got.is_done !== 1'b0 || got.rel != rel || got.ph !== phase || got.rem !== remaining) begin
                        errors++;
                        $display("FAIL step_event got rel=%0d ph=%0d rem=%0d want done=%b rel=%0d ph=%0d rem=%0d",
                                 rel, phase, remaining, got.is_done, got.rel, got.ph, got.rem);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done rel=%0d got done=1 want 0", rel);
                end else begin
                    got = exp_q.pop_front();
                    if (got.is_done !== 1'b1 || got.rel != rel || busy !== 1'b0 || got.rem !== remaining) begin
                        errors++;
                        $display("FAIL done_event got rel=%0d busy=%b rem=%0d want done=%b rel=%0d busy=0 rem=%0d",
                                 rel, busy, remaining, got.is_done, got.rel, got.rem);
                    end
                end
            end
            prev_step = step;
            // Scramble command inputs mid-move; only an explicit restart raises start.
            start     = (rel == restart_at);
            abort     = (rel == abort_at);
            dir_in    = $urandom_range(1, 0);
            steps_in  = (rel == restart_at) ? CNT_W'(5) : CNT_W'($urandom_range(60, 1));
            period_in = CNT_W'($urandom_range(40, 1));
        end
        start = 1'b0; abort = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (remaining !== CNT_W'(n - issued) || dir !== m_dir) begin
            errors++;
            $display("FAIL end_state got rem=%0d dir=%b want rem=%0d dir=%b",
                     remaining, dir, n - issued, m_dir);
        end
    endtask

    task automatic test_forward();
        do_move(1'b1, 3, 10, -1, -1);
    endtask

    task automatic test_clamp();
        test_reset();
        do_move(1'b0, 2, 2, -1, -1);
    endtask

    task automatic test_zero_steps();
        do_move(1'b1, 0, 12, -1, -1);
    endtask

    task automatic test_abort();
        do_move(1'b1, 100, 20, 45, -1);
    endtask

    task automatic test_abort_blocks_start();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; dir_in = ~m_dir; steps_in = CNT_W'(4); period_in = CNT_W'(9);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || step !== 1'b0 || done !== 1'b0 || dir !== m_dir || phase !== m_phase) begin
                errors++;
                $display("FAIL abort_blocks_start got busy=%b step=%b done=%b dir=%b ph=%0d want 0 0 0 %b %0d",
                         busy, step, done, dir, phase, m_dir, m_phase);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        do_move(1'b1, 4, 9, -1, 5);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coils !== 4'b0000 || phase !== m_phase || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got coils=%b ph=%0d busy=%b want coils=0000 ph=%0d busy=0",
                     coils, phase, busy, m_phase);
        end
    endtask

    task automatic test_reset_mid_move();
        hold = 1'b1;
        @(negedge clk);
        dir_in = 1'b1; steps_in = CNT_W'(10); period_in = CNT_W'(10); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({step, dir, busy, done, remaining, phase, coils} !== '0) begin
            errors++;
            $display("FAIL async_reset got step=%b dir=%b busy=%b done=%b rem=%0d ph=%0d coils=%b want all zero",
                     step, dir, busy, done, remaining, phase, coils);
        end
        @(negedge clk);
        rst = 1'b0;
        m_phase = 2'd0; m_dir = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || coils !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset got busy=%b done=%b coils=%b want 0 0 0001", busy, done, coils);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_clamp();
        test_zero_steps();
        test_abort();
        test_abort_blocks_start();
        test_back_to_back();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
